// File: rtl/train_timer_bank_if.sv
// Control/status bundle for train_timer_bank: per-channel strobes in, per-channel
// status and live counts out. Vectors are packed channel-major (channel i at [i*WIDTH +: WIDTH]).
interface train_timer_bank_if #(
    parameter int NCH   = 4,
    parameter int WIDTH = 19
);
    logic [NCH-1:0]       load;
    logic [NCH*WIDTH-1:0] load_val;
    logic [NCH-1:0]       mode;
    logic [NCH-1:0]       pause;
    logic [NCH-1:0]       clear;
    logic [NCH-1:0]       expired;
    logic [NCH-1:0]       done;
    logic [NCH*WIDTH-1:0] count;
    logic                 busy;

    modport master (
        output load, load_val, mode, pause, clear,
        input  expired, done, count, busy
    );

    modport slave (
        input  load, load_val, mode, pause, clear,
        output expired, done, count, busy
    );
endinterface

// File: rtl/train_timer_bank.sv
// Bank of NCH independent down-counting timers sharing one clk prescaler.
// Each channel: load/clear/pause, one-shot or auto-reload, expired level and done pulse.
module train_timer_bank #(
    parameter int WIDTH    = 19,
    parameter int NCH      = 4,
    parameter int PRESCALE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    train_timer_bank_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } chan_state_e;

    logic tick;

    // Shared prescaler; free-running and never restarted by a load.
    generate
        if (PRESCALE <= 1) begin : g_no_presc
            assign tick = 1'b1;
        end else begin : g_presc
            localparam int PW = $clog2(PRESCALE);
            logic [PW-1:0] presc_q;
            logic [PW-1:0] presc_d;

            always_comb begin
                presc_d = presc_q + PW'(1);
                if (presc_q == PW'(PRESCALE - 1)) begin
                    presc_d = '0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    presc_q <= '0;
                end else begin
                    presc_q <= presc_d;
                end
            end

            assign tick = (presc_q == PW'(PRESCALE - 1));
        end
    endgenerate

    logic [NCH-1:0] expired_w;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            chan_state_e      state_q, state_d;
            logic [WIDTH-1:0] count_q, count_d;
            logic [WIDTH-1:0] reload_q, reload_d;
            logic             mode_q, mode_d;
            logic             done_q, done_d;
            logic [WIDTH-1:0] load_val_w;

            assign load_val_w = bus.load_val[gi*WIDTH +: WIDTH];

            always_comb begin
                state_d  = state_q;
                count_d  = count_q;
                reload_d = reload_q;
                mode_d   = mode_q;
                done_d   = 1'b0;

                if (bus.clear[gi]) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (bus.load[gi]) begin
                    reload_d = load_val_w;
                    mode_d   = bus.mode[gi];
                    if (load_val_w == '0) begin
                        // A zero-length timer completes on the load edge itself.
                        state_d = ST_IDLE;
                        count_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        count_d = load_val_w;
                    end
                end else if (state_q != ST_IDLE) begin
                    if (bus.pause[gi]) begin
                        // Ticks seen while paused are dropped, not queued.
                        state_d = ST_HOLD;
                    end else begin
                        // Releasing pause resumes counting on the same edge.
                        state_d = ST_RUN;
                        if (tick) begin
                            if (count_q > WIDTH'(1)) begin
                                count_d = count_q - WIDTH'(1);
                            end else begin
                                done_d = 1'b1;
                                if (mode_q) begin
                                    count_d = reload_q;
                                end else begin
                                    state_d = ST_IDLE;
                                    count_d = '0;
                                end
                            end
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q  <= ST_IDLE;
                    count_q  <= '0;
                    reload_q <= '0;
                    mode_q   <= 1'b0;
                    done_q   <= 1'b0;
                end else begin
                    state_q  <= state_d;
                    count_q  <= count_d;
                    reload_q <= reload_d;
                    mode_q   <= mode_d;
                    done_q   <= done_d;
                end
            end

            assign expired_w[gi]                 = (state_q == ST_IDLE);
            assign bus.done[gi]                  = done_q;
            assign bus.count[gi*WIDTH +: WIDTH]  = count_q;
        end
    endgenerate

    assign bus.expired = expired_w;
    assign bus.busy    = |(~expired_w);

endmodule

// File: tb/tb_train_timer_bank.sv
// Directed bench for train_timer_bank: one PRESCALE=1 instance for the main scenarios
// and one PRESCALE=4 instance for prescaled timing and full-width loads.
module tb_train_timer_bank;
    localparam int W = 19;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    train_timer_bank_if #(.NCH(N), .WIDTH(W)) bus_a ();
    train_timer_bank_if #(.NCH(N), .WIDTH(W)) bus_b ();

    train_timer_bank #(.WIDTH(W), .NCH(N), .PRESCALE(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    train_timer_bank #(.WIDTH(W), .NCH(N), .PRESCALE(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cnt_a(input int i);
        return 32'(bus_a.count[i*W +: W]);
    endfunction

    function automatic logic [31:0] cnt_b(input int i);
        return 32'(bus_b.count[i*W +: W]);
    endfunction

    initial begin
        int when_done;
        logic [31:0] cap;

        bus_a.load = '0; bus_a.load_val = '0; bus_a.mode = '0; bus_a.pause = '0; bus_a.clear = '0;
        bus_b.load = '0; bus_b.load_val = '0; bus_b.mode = '0; bus_b.pause = '0; bus_b.clear = '0;

        // Reset state
        step(); step();
        check("rst_count0", cnt_a(0), 0);
        check("rst_expired", 32'(bus_a.expired), 32'hF);
        check("rst_done", 32'(bus_a.done), 0);
        check("rst_busy", 32'(bus_a.busy), 0);
        check("rst_expired_b", 32'(bus_b.expired), 32'hF);
        rst_n = 1'b1;
        $display("txn reset: released");

        // Reset mid-count
        bus_a.load[0] = 1'b1; bus_a.load_val[0*W +: W] = W'(100);
        step();
        bus_a.load = '0;
        check("mid_load_count0", cnt_a(0), 100);
        check("mid_load_expired", 32'(bus_a.expired), 32'hE);
        check("mid_load_busy", 32'(bus_a.busy), 1);
        for (int j = 0; j < 10; j++) step();
        check("mid_count0_after10", cnt_a(0), 90);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_count0", cnt_a(0), 0);
        check("async_rst_expired", 32'(bus_a.expired), 32'hF);
        check("async_rst_done", 32'(bus_a.done), 0);
        step();
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) step();
        check("post_rst_done", 32'(bus_a.done), 0);
        check("post_rst_expired", 32'(bus_a.expired), 32'hF);
        $display("txn reset mid-count: done");

        // One-shot ch1 N=5
        bus_a.load[1] = 1'b1; bus_a.load_val[1*W +: W] = W'(5);
        step();
        bus_a.load = '0;
        check("os_count_k", cnt_a(1), 5);
        for (int j = 1; j <= 4; j++) begin
            step();
            check("os_count", cnt_a(1), 32'(5 - j));
            check("os_expired_run", 32'(bus_a.expired[1]), 0);
            check("os_done_run", 32'(bus_a.done[1]), 0);
        end
        step();
        check("os_count_end", cnt_a(1), 0);
        check("os_expired_end", 32'(bus_a.expired[1]), 1);
        check("os_done_end", 32'(bus_a.done[1]), 1);
        step();
        check("os_done_after", 32'(bus_a.done[1]), 0);
        $display("txn one-shot ch1 N=5: done");

        // Periodic ch2 N=3; mode dropped after load must be ignored
        bus_a.load[2] = 1'b1; bus_a.load_val[2*W +: W] = W'(3); bus_a.mode[2] = 1'b1;
        step();
        bus_a.load = '0; bus_a.mode = '0;
        for (int p = 1; p <= 15; p++) begin
            step();
            check("per_count", cnt_a(2), (p % 3 == 0) ? 32'd3 : 32'(3 - (p % 3)));
            check("per_done", 32'(bus_a.done[2]), (p % 3 == 0) ? 32'd1 : 32'd0);
            check("per_expired", 32'(bus_a.expired[2]), 0);
        end
        bus_a.clear[2] = 1'b1;
        step();
        bus_a.clear = '0;
        check("per_clear_count", cnt_a(2), 0);
        check("per_clear_expired", 32'(bus_a.expired[2]), 1);
        check("per_clear_done", 32'(bus_a.done[2]), 0);
        $display("txn periodic ch2 N=3: done");

        // Pause ch0 N=8
        bus_a.load[0] = 1'b1; bus_a.load_val[0*W +: W] = W'(8);
        step();
        bus_a.load = '0;
        step(); step(); step();
        check("pause_pre", cnt_a(0), 5);
        bus_a.pause[0] = 1'b1;
        for (int j = 0; j < 6; j++) step();
        check("pause_hold_count", cnt_a(0), 5);
        check("pause_hold_expired", 32'(bus_a.expired[0]), 0);
        bus_a.pause[0] = 1'b0;
        for (int j = 0; j < 4; j++) step();
        check("pause_rel4_count", cnt_a(0), 1);
        check("pause_rel4_done", 32'(bus_a.done[0]), 0);
        step();
        check("pause_rel5_count", cnt_a(0), 0);
        check("pause_rel5_done", 32'(bus_a.done[0]), 1);
        check("pause_rel5_expired", 32'(bus_a.expired[0]), 1);
        bus_a.clear[0] = 1'b1; bus_a.load[0] = 1'b1; bus_a.load_val[0*W +: W] = W'(9);
        step();
        bus_a.clear = '0; bus_a.load = '0;
        check("clr_ld_count", cnt_a(0), 0);
        check("clr_ld_expired", 32'(bus_a.expired[0]), 1);
        check("clr_ld_done", 32'(bus_a.done[0]), 0);
        $display("txn pause/priority ch0: done");

        // Load during HOLD with pause held
        bus_a.load[1] = 1'b1; bus_a.load_val[1*W +: W] = W'(10);
        step();
        bus_a.load = '0; bus_a.pause[1] = 1'b1;
        step();
        check("hold_count", cnt_a(1), 10);
        bus_a.load[1] = 1'b1; bus_a.load_val[1*W +: W] = W'(4);
        step();
        bus_a.load = '0;
        check("hold_load_count", cnt_a(1), 4);
        check("hold_load_expired", 32'(bus_a.expired[1]), 0);
        step();
        check("hold_again_count", cnt_a(1), 4);
        bus_a.clear[1] = 1'b1; bus_a.pause = '0;
        step();
        bus_a.clear = '0;
        $display("txn load during hold ch1: done");

        // Zero load then restart ch3
        bus_a.load[3] = 1'b1; bus_a.load_val[3*W +: W] = W'(0);
        step();
        bus_a.load = '0;
        check("zero_done", 32'(bus_a.done[3]), 1);
        check("zero_expired", 32'(bus_a.expired[3]), 1);
        check("zero_count", cnt_a(3), 0);
        step();
        check("zero_done_after", 32'(bus_a.done[3]), 0);
        check("zero_expired_after", 32'(bus_a.expired[3]), 1);
        bus_a.load[3] = 1'b1; bus_a.load_val[3*W +: W] = W'(20);
        step();
        bus_a.load = '0;
        for (int j = 0; j < 13; j++) step();
        check("reld_mid", cnt_a(3), 7);
        bus_a.load[3] = 1'b1;
        step();
        bus_a.load = '0;
        check("reld_restart", cnt_a(3), 20);
        check("reld_done", 32'(bus_a.done[3]), 0);
        bus_a.clear[3] = 1'b1;
        step();
        bus_a.clear = '0;
        $display("txn zero load / reload ch3: done");

        // Simultaneous terminal on two channels
        bus_a.load[1:0] = 2'b11; bus_a.load_val[0*W +: W] = W'(2); bus_a.load_val[1*W +: W] = W'(2);
        step();
        bus_a.load = '0;
        step(); step();
        check("simul_done", 32'(bus_a.done), 32'h3);
        check("simul_busy", 32'(bus_a.busy), 0);
        $display("txn simultaneous ch0/ch1: done");

        // PRESCALE=4
        bus_b.load[1:0] = 2'b11;
        bus_b.load_val[0*W +: W] = {W{1'b1}};
        bus_b.load_val[1*W +: W] = W'(3);
        step();
        bus_b.load = '0;
        check("pre_big_load", cnt_b(0), 32'h7FFFF);
        check("pre_small_load", cnt_b(1), 3);
        when_done = 0;
        cap = '0;
        for (int c = 1; c <= 16; c++) begin
            step();
            if (c == 8) cap = cnt_b(0);
            if (bus_b.done[1] && when_done == 0) when_done = c;
        end
        check("pre_big_after8", cap, 32'h7FFFD);
        check("pre_small_latency_ok", (when_done >= 9 && when_done <= 12) ? 32'd1 : 32'd0, 32'd1);
        check("pre_small_expired", 32'(bus_b.expired[1]), 1);
        $display("txn prescale=4: small done at cycle %0d", when_done);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/train_timer_bank.md
Name: train_timer_bank

Overview:
- Bank of NCH independent programmable down-counting timers for the train controller FSM (door dwell, station stop, crossing hold, etc.).
- Each channel has:
  - synchronous load of a duration;
  - one-shot or periodic (auto-reload) mode;
  - pause and clear controls;
  - a level `expired` flag, a one-cycle `done` pulse, and a readable live count.
- A shared prescaler divides clk so long durations fit in WIDTH bits.

Parameters:
- WIDTH, 19, bit width of each channel's duration/count.
- NCH, 4, number of independent timer channels.
- PRESCALE, 1, clk cycles per count tick (1 = decrement every cycle); must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  NCH  per-channel load strobe, one cycle.
- load_val  input  NCH*WIDTH  duration for channel i at bits [i*WIDTH +: WIDTH].
- mode  input  NCH  per-channel mode, latched on load: 0 = one-shot, 1 = periodic.
- pause  input  NCH  per-channel hold (level); count frozen while high.
- clear  input  NCH  per-channel abort strobe.
- expired  output  NCH  level: 1 when the channel is idle/expired, 0 while counting.
- done  output  NCH  one-cycle pulse when the channel's count reaches terminal.
- count  output  NCH*WIDTH  live count per channel, same packing as load_val.
- busy  output  1  OR of ~expired over all channels.

Behaviour:
- Reset (async, rst_n=0):
  - count=0, expired=all 1s, done=0, busy=0;
  - reload registers=0, mode latches=0, prescaler=0;
  - takes effect immediately, including mid-count; no done pulse is generated by reset.
- Prescaler:
  - free-running counter 0..PRESCALE-1; tick=1 in the cycle it equals PRESCALE-1;
  - PRESCALE=1 gives tick every cycle;
  - not reset by load, so the first decrement after a load occurs 1..PRESCALE cycles later.
- Per-channel states: IDLE (expired=1), RUN (expired=0), HOLD (expired=0, paused).
- Per-channel priority each cycle: clear > load > pause > tick-decrement.
- clear: count<=0, state IDLE, expired<=1, done stays 0. Clear on the same cycle as terminal count also suppresses done.
- load, load_val=N>0:
  - count<=N, reload<=N, mode latched, state RUN;
  - expired<=0 on the same edge;
  - any in-flight count is discarded (restart).
- load, load_val=0: count<=0, state IDLE, expired<=1, done<=1 for one cycle (zero-length timer completes immediately).
- RUN and pause=1 -> HOLD; count is not decremented and ticks are lost (not queued). HOLD and pause=0 -> RUN.
- RUN, tick, count>1: count<=count-1.
- RUN, tick, count==1:
  - one-shot: count<=0, state IDLE, expired<=1, done<=1 (same edge);
  - periodic: count<=reload, stay RUN, expired stays 0, done<=1.
- Periodic with reload=1: done high every tick.
- done is otherwise 0 and never asserted for more than one cycle per terminal event. With PRESCALE=1 and reload=1, done stays high continuously while in RUN.
- Latency, PRESCALE=1, load N at edge k: count=N after edge k, then count=0, expired=1, done=1 after edge k+N.
- Load while IDLE or HOLD is legal. Load during HOLD enters RUN even if pause is still high; pause is then honoured from the next cycle.
- Arithmetic: unsigned WIDTH-bit; no wrap below 0, since decrement only occurs when count>=2 or on the terminal transition.
- Channels are fully independent. Simultaneous events on different channels are all honoured in the same cycle.
- busy is a registered-equivalent combinational OR of the channel states; no extra latency beyond expired.
- mode changes outside a load cycle have no effect.

Test Plan:
- Reset mid-count: load ch0 N=100, run 10 cycles, pulse rst_n low -> count0=0, expired=4'b1111, done=0 immediately; no done afterwards.
- One-shot, PRESCALE=1: load ch1 N=5 at edge k -> count1 steps 5,4,3,2,1,0; expired[1]=0 for edges k..k+4; expired[1]=1 and done[1]=1 exactly at edge k+5; done[1]=0 at k+6.
- Periodic: ch2 mode=1, N=3 -> done[2] pulses every 3 cycles for 5 periods, expired[2] stays 0; then clear[2] -> count2=0, expired[2]=1, no done.
- Pause/priority: ch0 N=8, pause after 3 ticks for 6 cycles -> count holds at 5, then finishes 5 cycles after release. clear and load on the same cycle -> IDLE, count0=0.
- Zero load and reload: load ch3 N=0 -> done[3] one cycle, expired[3] stays 1. Reload ch3 N=20 mid-count at count=7 -> restarts at 20.
- PRESCALE=4, WIDTH=19: load N=2^19-1 and N=3 on two channels -> N=3 expires 9..12 cycles after load. Large N decrements once per 4 cycles, with no overflow at load.
